voice_allocator: RTL and testbench



---
 rtl/voice_if.sv | 26 ++
 rtl/voice_allocator.sv | 229 ++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/voice_if.sv
// Event handshake between the keypad front end (master) and the voice
// allocator (slave). One note-on/note-off event transfers per cycle in which
// ev_valid and ev_ready are both high.
interface voice_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_on;
  logic [3:0] ev_note;
  logic [1:0] ev_octave;

  modport master (
    output ev_valid,
    output ev_on,
    output ev_note,
    output ev_octave,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_on,
    input  ev_note,
    input  ev_octave,
    output ev_ready
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler. Each accepted event is scanned against every
// voice (one voice per cycle), then committed in a single cycle: retrigger a
// matching voice, fill the lowest free voice, or handle an all-busy note-on.
// Optional feature macro: VOICE_STEAL_EN -- when defined, an all-busy note-on
// reassigns the oldest active voice and pulses steal; otherwise the note is
// dropped and drop pulses.
module voice_allocator #(
  parameter int NVOICES = 4,
  parameter int DIV_W   = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  voice_if.slave                   ev,
  output logic [NVOICES-1:0]       voice_en,
  output logic [NVOICES*DIV_W-1:0] voice_div,
  output logic [2*NVOICES-1:0]     voice_oct,
  output logic                     busy,
  output logic                     steal,
  output logic                     drop
);

  localparam int AW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [AW-1:0] LAST    = AW'(NVOICES - 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(NVOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t state, state_nxt;

  // Per-voice state; div and oct are held at 0 while a voice is inactive so
  // the outputs can be wired straight from these registers.
  logic [NVOICES-1:0] active;
  logic [3:0]         note_r [NVOICES];
  logic [DIV_W-1:0]   div_r  [NVOICES];
  logic [1:0]         oct_r  [NVOICES];
  logic [AW-1:0]      age_r  [NVOICES];

  // Latched event and scan results.
  logic          lat_on;
  logic [3:0]    lat_note;
  logic [1:0]    lat_oct;
  logic [AW-1:0] idx;
  logic          match_hit;
  logic [AW-1:0] match_idx;
  logic          free_hit;
  logic [AW-1:0] free_idx;
`ifdef VOICE_STEAL_EN
  logic          old_hit;
  logic [AW-1:0] old_idx;
  logic [AW-1:0] old_age;
`endif

  // Divider for the 13 notes C4..C5 at a 10 MHz clock.
  function automatic logic [DIV_W-1:0] div_lut(input logic [3:0] n);
    logic [31:0] d;
    case (n)
      4'd0:    d = 32'd38222;
      4'd1:    d = 32'd36077;
      4'd2:    d = 32'd34053;
      4'd3:    d = 32'd32141;
      4'd4:    d = 32'd30337;
      4'd5:    d = 32'd28635;
      4'd6:    d = 32'd27027;
      4'd7:    d = 32'd25510;
      4'd8:    d = 32'd24078;
      4'd9:    d = 32'd22727;
      4'd10:   d = 32'd21451;
      4'd11:   d = 32'd20247;
      4'd12:   d = 32'd19111;
      default: d = 32'd0;
    endcase
    return d[DIV_W-1:0];
  endfunction

  // Age increment that saturates at the oldest possible rank.
  function automatic logic [AW-1:0] age_inc(input logic [AW-1:0] a);
    if (a == AGE_MAX) return a;
    return a + AW'(1);
  endfunction

  assign ev.ev_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign voice_en    = active;

  for (genvar g = 0; g < NVOICES; g++) begin : g_out
    assign voice_div[g*DIV_W +: DIV_W] = div_r[g];
    assign voice_oct[2*g +: 2]         = oct_r[g];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: one handshake, NVOICES scan cycles, one commit cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ev.ev_valid) state_nxt = SCAN;
      SCAN:    if (idx == LAST) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Event latch and sequential scan of one voice per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_on    <= 1'b0;
      lat_note  <= '0;
      lat_oct   <= '0;
      idx       <= '0;
      match_hit <= 1'b0;
      match_idx <= '0;
      free_hit  <= 1'b0;
      free_idx  <= '0;
`ifdef VOICE_STEAL_EN
      old_hit   <= 1'b0;
      old_idx   <= '0;
      old_age   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ev.ev_valid) begin
            lat_on    <= ev.ev_on;
            lat_note  <= ev.ev_note;
            lat_oct   <= ev.ev_octave;
            idx       <= '0;
            match_hit <= 1'b0;
            free_hit  <= 1'b0;
`ifdef VOICE_STEAL_EN
            old_hit   <= 1'b0;
`endif
          end
        end
        SCAN: begin
          idx <= idx + AW'(1);
          if (!match_hit && active[idx] && (note_r[idx] == lat_note)) begin
            match_hit <= 1'b1;
            match_idx <= idx;
          end
          if (!free_hit && !active[idx]) begin
            free_hit <= 1'b1;
            free_idx <= idx;
          end
`ifdef VOICE_STEAL_EN
          // Strict compare keeps the lowest index on equal ages.
          if (active[idx] && (!old_hit || (age_r[idx] > old_age))) begin
            old_hit <= 1'b1;
            old_idx <= idx;
            old_age <= age_r[idx];
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Commit: update per-voice state and issue the steal/drop pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
      for (int v = 0; v < NVOICES; v++) begin
        note_r[v] <= '0;
        div_r[v]  <= '0;
        oct_r[v]  <= '0;
        age_r[v]  <= '0;
      end
      drop <= 1'b0;
`ifdef VOICE_STEAL_EN
      steal <= 1'b0;
`endif
    end else begin
      drop <= 1'b0;
`ifdef VOICE_STEAL_EN
      steal <= 1'b0;
`endif
      if ((state == COMMIT) && (lat_note <= 4'd12)) begin
        if (lat_on) begin
          if (match_hit) begin
            oct_r[match_idx] <= lat_oct;
            age_r[match_idx] <= '0;
          end else if (free_hit) begin
            for (int v = 0; v < NVOICES; v++) begin
              if (AW'(v) == free_idx) begin
                active[v] <= 1'b1;
                note_r[v] <= lat_note;
                div_r[v]  <= div_lut(lat_note);
                oct_r[v]  <= lat_oct;
                age_r[v]  <= '0;
              end else if (active[v]) begin
                age_r[v] <= age_inc(age_r[v]);
              end
            end
          end else begin
`ifdef VOICE_STEAL_EN
            for (int v = 0; v < NVOICES; v++) begin
              if (AW'(v) == old_idx) begin
                note_r[v] <= lat_note;
                div_r[v]  <= div_lut(lat_note);
                oct_r[v]  <= lat_oct;
                age_r[v]  <= '0;
              end else if (active[v]) begin
                age_r[v] <= age_inc(age_r[v]);
              end
            end
            steal <= 1'b1;
`else
            drop <= 1'b1;
`endif
          end
        end else if (match_hit) begin
          active[match_idx] <= 1'b0;
          div_r[match_idx]  <= '0;
          oct_r[match_idx]  <= '0;
          age_r[match_idx]  <= '0;
        end
      end
    end
  end

`ifndef VOICE_STEAL_EN
  assign steal = 1'b0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator at default parameters (4 voices,
// 18-bit dividers). Expected values are hand-computed from the note table.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int DW = 18;

  logic              clk;
  logic              rst;
  logic [NV-1:0]     voice_en;
  logic [NV*DW-1:0]  voice_div;
  logic [2*NV-1:0]   voice_oct;
  logic              busy;
  logic              steal;
  logic              drop;

  voice_if vif();

  voice_allocator #(.NVOICES(NV), .DIV_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ev        (vif),
    .voice_en  (voice_en),
    .voice_div (voice_div),
    .voice_oct (voice_oct),
    .busy      (busy),
    .steal     (steal),
    .drop      (drop)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int steal_cnt;
  int drop_cnt;
  logic busy1;
  logic [NV-1:0]    en_save;
  logic [NV*DW-1:0] div_save;
  logic [2*NV-1:0]  oct_save;

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dv(input int v);
    return voice_div[v*DW +: DW];
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issue one event and follow it until ev_ready returns, counting pulses.
  task automatic send(input logic on, input logic [3:0] n, input logic [1:0] o);
    int k;
    steal_cnt = 0;
    drop_cnt  = 0;
    lat       = -1;
    k = 0;
    while (!vif.ev_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    vif.ev_on     = on;
    vif.ev_note   = n;
    vif.ev_octave = o;
    vif.ev_valid  = 1'b1;
    @(posedge clk); #1;
    busy1 = busy;
    // Scramble the inputs; they must be ignored once the event is latched.
    vif.ev_valid  = 1'b0;
    vif.ev_on     = ~on;
    vif.ev_note   = n ^ 4'h6;
    vif.ev_octave = ~o;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      steal_cnt += int'(steal);
      drop_cnt  += int'(drop);
      if (vif.ev_ready) begin
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
    steal_cnt += int'(steal);
    drop_cnt  += int'(drop);
  endtask

  initial begin
    rst           = 1'b1;
    vif.ev_valid  = 1'b0;
    vif.ev_on     = 1'b0;
    vif.ev_note   = 4'd0;
    vif.ev_octave = 2'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    check("rst_ready", vif.ev_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_en",    voice_en, 0);
    check("rst_div",   voice_div, 0);
    check("rst_oct",   voice_oct, 0);
    check("rst_steal", steal, 0);
    check("rst_drop",  drop, 0);

    // Single note-on A4.
    send(1'b1, 4'd9, 2'd0);
    check("n9_busy", busy1, 1);
    check("n9_lat",  lat, 5);
    check("n9_en",   voice_en, 4'b0001);
    check("n9_div0", dv(0), 22727);
    check("n9_puls", steal_cnt + drop_cnt, 0);

    // Fill all four voices.
    do_reset();
    send(1'b1, 4'd0,  2'd1);
    send(1'b1, 4'd4,  2'd2);
    send(1'b1, 4'd7,  2'd3);
    send(1'b1, 4'd12, 2'd0);
    check("full_en",   voice_en, 4'b1111);
    check("full_div0", dv(0), 38222);
    check("full_div1", dv(1), 30337);
    check("full_div2", dv(2), 25510);
    check("full_div3", dv(3), 19111);
    check("full_oct",  voice_oct, 8'b00_11_10_01);

    // All busy: note-on D4 either steals voice0 (oldest) or is dropped.
    send(1'b1, 4'd2, 2'd2);
    check("allbusy_lat", lat, 5);
    check("allbusy_en",  voice_en, 4'b1111);
`ifdef VOICE_STEAL_EN
    check("steal_div0", dv(0), 34053);
    check("steal_oct",  voice_oct, 8'b00_11_10_10);
    check("steal_cnt",  steal_cnt, 1);
    check("steal_drop", drop_cnt, 0);
`else
    check("drop_div0", dv(0), 38222);
    check("drop_oct",  voice_oct, 8'b00_11_10_01);
    check("drop_cnt",  drop_cnt, 1);
    check("drop_steal", steal_cnt, 0);
`endif

    // Note-off G4 frees voice2; the next note-on reuses it.
    send(1'b0, 4'd7, 2'd0);
    check("off7_en",   voice_en, 4'b1011);
    check("off7_div2", dv(2), 0);
    check("off7_oct2", voice_oct[5:4], 0);
    check("off7_puls", steal_cnt + drop_cnt, 0);
    send(1'b1, 4'd5, 2'd1);
    check("on5_en",   voice_en, 4'b1111);
    check("on5_div2", dv(2), 28635);
    check("on5_oct2", voice_oct[5:4], 1);

    // Retrigger C5 on voice3 with a new octave; divider unchanged.
    send(1'b1, 4'd12, 2'd2);
    check("retrig_oct3", voice_oct[7:6], 2);
    check("retrig_div3", dv(3), 19111);
    check("retrig_puls", steal_cnt + drop_cnt, 0);

    // Invalid notes and a note-off for an inactive note leave state alone.
    en_save  = voice_en;
    div_save = voice_div;
    oct_save = voice_oct;
    send(1'b1, 4'd14, 2'd3);
    check("inv_on_lat",  lat, 5);
    check("inv_on_puls", steal_cnt + drop_cnt, 0);
    send(1'b0, 4'd14, 2'd0);
    check("inv_off_lat", lat, 5);
    send(1'b0, 4'd11, 2'd0);
    check("off11_lat",  lat, 5);
    check("off11_puls", steal_cnt + drop_cnt, 0);
    check("nochg_en",   voice_en, en_save);
    check("nochg_div",  voice_div, div_save);
    check("nochg_oct",  voice_oct, oct_save);

`ifdef VOICE_STEAL_EN
    // Oldest voice is now voice1 (age saturated at 3).
    send(1'b1, 4'd9, 2'd0);
    check("steal2_div1", dv(1), 22727);
    check("steal2_div0", dv(0), 34053);
    check("steal2_cnt",  steal_cnt, 1);
`else
    send(1'b1, 4'd9, 2'd0);
    check("drop2_div1", dv(1), 30337);
    check("drop2_cnt",  drop_cnt, 1);
`endif

    // Reset while scanning a note-on: event is discarded.
    vif.ev_on     = 1'b1;
    vif.ev_note   = 4'd3;
    vif.ev_octave = 2'd1;
    vif.ev_valid  = 1'b1;
    @(posedge clk); #1;
    vif.ev_valid  = 1'b0;
    @(posedge clk); #1;
    check("scan_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", vif.ev_ready, 1);
    check("abort_busy",  busy, 0);
    check("abort_en",    voice_en, 0);
    check("abort_div",   voice_div, 0);
    check("abort_oct",   voice_oct, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    check("abort_en_later", voice_en, 0);
    check("abort_idle",     vif.ev_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
